// File: rtl/argo_chan_pkg.sv
// Shared helpers for the Argo channel FIFO: counter/pointer sizing and
// modulo-DEPTH pointer increment (DEPTH need not be a power of two).
package argo_chan_pkg;

  function automatic int cnt_width(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 32'd1) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/argo_chan_ram.sv
// DEPTH x DATA_WIDTH flop storage: synchronous write, asynchronous read.
module argo_chan_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int PTR_W      = 3
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [PTR_W-1:0]      waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [PTR_W-1:0]      raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/argo_chan_fifo.sv
// Go-style channel between two Argo processes: buffered FIFO for DEPTH>0,
// unbuffered rendezvous for DEPTH=0, with sticky close and receive-side ok flag.
module argo_chan_fifo
  import argo_chan_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int DEPTH        = 8,
  parameter int AFULL_THRESH = DEPTH - 1,
  localparam int CNT_WIDTH   = cnt_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_ok,
  input  logic                  close,
  output logic                  closed,
  output logic [CNT_WIDTH-1:0]  level,
  output logic                  almost_full
);

  logic closed_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       closed_q <= 1'b0;
    else if (close) closed_q <= 1'b1;
  end

  assign closed = closed_q;

  generate
    if (DEPTH == 0) begin : g_rdv
      // Rendezvous: the receiver sees the sender's offer directly.
      assign wr_ready    = rst && rd_ready && !closed_q;
      assign rd_valid    = rst && (wr_valid || closed_q);
      assign rd_ok       = rst && wr_valid && !closed_q;
      assign rd_data     = rd_ok ? wr_data : '0;
      assign level       = '0;
      assign almost_full = 1'b1;
    end else begin : g_buf
      localparam int PW = ptr_width(DEPTH);

      logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
      logic [CNT_WIDTH-1:0]  level_q, level_d;
      logic [DATA_WIDTH-1:0] ram_rdata;
      logic                  push, pop;

      assign wr_ready = rst && (level_q != CNT_WIDTH'(DEPTH)) && !closed_q;
      assign rd_valid = rst && ((level_q != '0) || closed_q);
      assign rd_ok    = (level_q != '0);
      assign rd_data  = rd_ok ? ram_rdata : '0;

      assign push = wr_valid && wr_ready;
      // Popping a closed, drained channel must leave state untouched.
      assign pop  = rd_valid && rd_ready && rd_ok;

      always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) wr_ptr_d = PW'(ptr_inc(32'(wr_ptr_q), DEPTH));
        if (pop)  rd_ptr_d = PW'(ptr_inc(32'(rd_ptr_q), DEPTH));
        if (push && !pop)      level_d = level_q + CNT_WIDTH'(1);
        else if (!push && pop) level_d = level_q - CNT_WIDTH'(1);
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          wr_ptr_q <= '0;
          rd_ptr_q <= '0;
          level_q  <= '0;
        end else begin
          wr_ptr_q <= wr_ptr_d;
          rd_ptr_q <= rd_ptr_d;
          level_q  <= level_d;
        end
      end

      argo_chan_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .PTR_W      (PW)
      ) u_ram (
        .clk     (clk),
        .we_i    (push),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_data),
        .raddr_i (rd_ptr_q),
        .rdata_o (ram_rdata)
      );

      assign level       = level_q;
      assign almost_full = (int'(level_q) >= AFULL_THRESH);
    end
  endgenerate

endmodule

// File: doc/argo_chan_fifo.md
Name: argo_chan_fifo

Overview:
Parametrised successor to the Argo channel FIFO. It implements Go channel semantics between two compiled Argo processes:
- valid/ready handshakes on both sides;
- arbitrary (non-power-of-2) depth;
- unbuffered rendezvous mode when DEPTH=0;
- close() support, with the receive-side ok flag.

The compiler instantiates one per channel, between the sender and receiver state machines.

Parameters:
DATA_WIDTH, 32, payload width in bits
DEPTH, 8, channel capacity in items; 0 selects rendezvous (unbuffered) mode; any value 0..1024 is legal
AFULL_THRESH, DEPTH-1, level at or above which almost_full asserts
CNT_WIDTH, $clog2(DEPTH+1) (min 1), width of the level counter; derived, not overridden

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
wr_valid  in  1  sender offers wr_data
wr_ready  out  1  channel accepts; a push occurs when wr_valid && wr_ready
wr_data  in  DATA_WIDTH  send payload
rd_valid  out  1  item (or closed indication) available
rd_ready  in  1  receiver takes; a pop occurs when rd_valid && rd_ready
rd_data  out  DATA_WIDTH  receive payload; 0 when rd_ok=0
rd_ok  out  1  1 = real item; 0 = channel closed and drained
close  in  1  single-cycle close request
closed  out  1  sticky closed flag
level  out  CNT_WIDTH  items currently stored
almost_full  out  1  level >= AFULL_THRESH

Behaviour:
- Reset (rst=0, asynchronous):
  - read/write pointers, level and closed all go to 0;
  - wr_ready=0, rd_valid=0, rd_ok=0, rd_data=0 while rst=0.
  - Reset mid-transfer discards all stored items; no push or pop completes on an edge where rst=0.
- Buffered mode (DEPTH>0):
  - Storage is a flop array: synchronous write, combinational read at the read pointer (show-ahead).
  - wr_ready = rst && (level != DEPTH) && !closed.
  - rd_valid = rst && ((level != 0) || closed).
  - rd_ok = (level != 0).
  - rd_data = mem[rd_ptr] when level != 0, else 0.
  - Latency: an item pushed at edge N is visible on rd_data/rd_valid after edge N.
  - No same-cycle write-to-read bypass: an empty channel gives rd_valid=0 in the push cycle.
  - Pointers increment on push/pop and wrap from DEPTH-1 to 0; there is no power-of-2 assumption.
  - level_next = level + push - pop. Simultaneous push and pop leaves level unchanged and advances both pointers.
  - Full (level==DEPTH): wr_ready=0, so a simultaneous pop does not admit a same-cycle push. The push lands the next cycle.
  - Empty and not closed: pops are impossible (rd_valid=0).
- Close:
  - close=1 sets closed at the next edge. It is idempotent and clears only on reset.
  - A push in the same cycle as close is accepted, because wr_ready is computed from the registered closed.
  - After closed=1, wr_ready=0 permanently.
  - Buffered items drain normally with rd_ok=1.
  - Once closed && level==0: rd_valid=1, rd_ok=0, rd_data=0.
  - A pop in that state is a no-op: state unchanged, repeatable forever.
- Rendezvous mode (DEPTH=0): no storage.
  - rd_valid = rst && (wr_valid || closed); rd_data = wr_data.
  - rd_ok = wr_valid && !closed; when rd_ok=0, rd_data=0.
  - wr_ready = rst && rd_ready && !closed.
  - The transfer completes in the cycle both sides handshake.
  - level=0, almost_full=1.
  - Close semantics are as above.
- almost_full is combinational from level. AFULL_THRESH > DEPTH means it never asserts (except DEPTH=0).
- No combinational path from wr_valid to wr_ready or from rd_ready to rd_valid in buffered mode.

Decomposition:
- Package argo_chan_pkg: the clog2-based CNT_WIDTH helper function and a pointer-wrap increment function (ptr==DEPTH-1 ? 0 : ptr+1).
- Sub-module argo_chan_ram: DEPTH x DATA_WIDTH flop array with synchronous write and asynchronous read. It is used only in buffered mode; the DEPTH=0 path is a generate branch with no RAM instance.

Test Plan:
1. DEPTH=8: push 1..8 with rd_ready=0 → wr_ready falls after the 8th push, level=8, almost_full=1 from level 7. Then pop all 8 → data 1..8 in order, rd_ok=1, level=0, rd_valid=0.
2. DEPTH=5 (non-power-of-2): 12 pushes interleaved with pops → pointers wrap 4→0, data order preserved, level never exceeds 5.
3. DEPTH=4, level=4, wr_valid=1 and rd_ready=1 together → the pop completes and the push is rejected that cycle. Next cycle the push completes; level returns to 4.
4. DEPTH=4: store 0xA,0xB, pulse close together with a push of 0xC → 0xC accepted, closed=1, wr_ready=0. Pops yield 0xA,0xB,0xC with rd_ok=1, then rd_valid=1, rd_ok=0, rd_data=0 on repeated pops.
5. DEPTH=0: wr_valid=1, wr_data=0x55, rd_ready=0 → rd_valid=1, wr_ready=0. Raise rd_ready → transfer in the same cycle, rd_data=0x55. After close → wr_ready=0, rd_valid=1, rd_ok=0.
6. DEPTH=8 with 3 items stored: drop rst between clock edges → level, closed and rd_valid go to 0 immediately, without waiting for a clock edge. After release → empty channel, first push is visible after one edge.
